spatz_vlsu_rob: RTL
===================

Name: spatz_vlsu_rob

Overview:
- Parametrised reorder buffer between the VLSU and the memory interface.
- The VLSU allocates a slot per outstanding memory request and tags the request with the slot id.
- Memory responses may return out of order and are written back by id.
- Data is released strictly in allocation order. Depth, data width and response tagging are generalised per instance.

Parameters:
- Depth, 4, number of slots; must be >= 2; need not be a power of two.
- DataWidth, spatz_pkg::ELEN, width of response data in bits.
- IdWidth, $clog2(Depth), derived; slot id width; not to be overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- alloc_valid_i  in  1  VLSU requests a slot
- alloc_ready_o  out  1  slot available
- alloc_id_o  out  IdWidth  id of the slot granted on alloc handshake
- rsp_valid_i  in  1  memory response valid; always accepted
- rsp_id_i  in  IdWidth  slot the response belongs to
- rsp_data_i  in  DataWidth  response data
- pop_valid_o  out  1  head slot holds data
- pop_ready_i  in  1  consumer takes head
- pop_data_o  out  DataWidth  head data
- empty_o  out  1  no slot allocated
- full_o  out  1  all slots allocated

Behaviour:
- State registers:
  - alloc_ptr, head_ptr: IdWidth each.
  - count: $clog2(Depth+1) bits, range 0..Depth.
  - per-slot filled bit and data register.
- Reset: pointers, count and filled bits are 0.
  - Outputs during and out of reset: alloc_ready_o=1, alloc_id_o=0, pop_valid_o=0, pop_data_o=0, empty_o=1, full_o=0.
- Allocation:
  - alloc_ready_o = (count < Depth); alloc_id_o = alloc_ptr.
  - On alloc_valid_i & alloc_ready_o: alloc_ptr advances; slot filled bit is cleared.
  - alloc_ready_o depends only on registered count, never on a same-cycle pop. When full, a pop in cycle t enables allocation in t+1.
- Pointer wrap: each pointer goes from Depth-1 to 0 by explicit compare, not by natural overflow.
- Response:
  - On rsp_valid_i, slot rsp_id_i stores rsp_data_i and its filled bit is set at the next edge.
  - Response to an unallocated slot or an already-filled slot: ignored, and a simulation assertion fires.
- Pop:
  - pop_valid_o = (count != 0) & filled[head_ptr]; pop_data_o = data[head_ptr] when valid, else 0.
  - On pop_valid_o & pop_ready_i: head_ptr advances and filled[head_ptr] clears.
  - pop_valid_o is held until handshake and pop_data_o is stable while valid.
- Latency: response at edge t -> pop_valid_o high in cycle t+1 if that slot is head. An empty-to-visible path takes 1 cycle.
- Count:
  - alloc-only: +1; pop-only: -1; both in the same cycle: unchanged.
  - Alloc and pop of the same slot index in one cycle is impossible, since that needs count==Depth and then alloc_ready_o=0.
- Simultaneous response and pop for different slots: both take effect.
- empty_o = (count==0); full_o = (count==Depth).
- Reset mid-operation: all outstanding slots are discarded. Late responses after reset hit unallocated slots and are ignored (assertion fires).

Optional Feature:
- Macro: SPATZ_VLSU_ROB_BYPASS_EN.
- Defined:
  - A response in cycle t whose rsp_id_i equals head_ptr, with head allocated and not filled, drives pop_valid_o=1 and pop_data_o=rsp_data_i combinationally in cycle t.
  - On a same-cycle pop handshake the slot is never marked filled and head advances.
  - Without handshake, the data is stored as normal.
- Undefined: no bypass; minimum response-to-pop latency is 1 cycle.

Decomposition:
- spatz_pkg additions:
  - localparam VlsuRobDepth (default 4).
  - typedef rob_id_t = logic [$clog2(VlsuRobDepth)-1:0].
  - typedef rob_data_t = elen_t, for top-level instantiation.
- No sub-module required. The two wrapping pointers may share one small internal counter function; the storage array stays inline as flops.

Test Plan:
- Reset then idle -> alloc_ready_o=1, empty_o=1, pop_valid_o=0, alloc_id_o=0.
- Allocate 4 slots (Depth=4), respond ids 3,1,0,2 with data 0xD3,0xD1,0xD0,0xD2 -> pops in order 0xD0,0xD1,0xD2,0xD3. pop_valid_o first rises the cycle after id 0 is written.
- Fill all 4 slots: alloc_ready_o=0, full_o=1. Pop once with a simultaneous alloc_valid_i -> alloc refused that cycle, granted next cycle with alloc_id_o=0, proving wrap.
- Depth=3 instance, 7 alloc/respond/pop rounds -> alloc_id_o sequence 0,1,2,0,1,2,0; data order preserved.
- Hold pop_ready_i=0 for 5 cycles with head filled -> pop_valid_o and pop_data_o stable; count unchanged.
- With SPATZ_VLSU_ROB_BYPASS_EN, response for head id 0 with data 0xAB and pop_ready_i=1 -> pop handshake in the same cycle, head_ptr=1 next cycle, slot 0 never filled. Without the macro -> pop occurs one cycle later.

Source files
------------

// File: rtl/spatz_vlsu_rob_pkg.sv
// Shared types and defaults for the VLSU reorder buffer.
package spatz_vlsu_rob_pkg;

    localparam int unsigned ELEN = 64;
    typedef logic [ELEN-1:0] elen_t;

    localparam int unsigned VlsuRobDepth = 4;
    typedef logic [$clog2(VlsuRobDepth)-1:0] rob_id_t;
    typedef elen_t rob_data_t;

endpackage

// File: rtl/spatz_vlsu_rob.sv
// Reorder buffer between the VLSU and memory. Slots are allocated in order,
// filled out of order by response id, and released strictly in allocation order.
// Optional macro SPATZ_VLSU_ROB_BYPASS_EN: a response to the unfilled head slot
// is presented on the pop port in the same cycle.
module spatz_vlsu_rob
    import spatz_vlsu_rob_pkg::*;
#(
    parameter int unsigned Depth     = VlsuRobDepth,
    parameter int unsigned DataWidth = ELEN,
    parameter int unsigned IdWidth   = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alloc_valid_i,
    output logic                 alloc_ready_o,
    output logic [IdWidth-1:0]   alloc_id_o,
    input  logic                 rsp_valid_i,
    input  logic [IdWidth-1:0]   rsp_id_i,
    input  logic [DataWidth-1:0] rsp_data_i,
    output logic                 pop_valid_o,
    input  logic                 pop_ready_i,
    output logic [DataWidth-1:0] pop_data_o,
    output logic                 empty_o,
    output logic                 full_o
);

    localparam int unsigned         CntWidth = $clog2(Depth + 1);
    localparam int unsigned         OffWidth = IdWidth + 1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
    localparam logic [OffWidth-1:0] DepthOff = OffWidth'(Depth);
    localparam logic [IdWidth-1:0]  LastId   = IdWidth'(Depth - 1);

    // Both pointers wrap at Depth-1 explicitly so non-power-of-two depths work.
    function automatic logic [IdWidth-1:0] ptr_inc(input logic [IdWidth-1:0] ptr);
        return (ptr == LastId) ? '0 : ptr + IdWidth'(1);
    endfunction

    logic [IdWidth-1:0]   alloc_ptr_reg, alloc_ptr_next;
    logic [IdWidth-1:0]   head_ptr_reg, head_ptr_next;
    logic [CntWidth-1:0]  count_reg, count_next;
    logic [Depth-1:0]     filled_reg, filled_next;
    logic [DataWidth-1:0] data_reg [Depth];

    logic                 alloc_fire;
    logic                 pop_fire;
    logic                 head_filled;
    logic                 rsp_in_range;
    logic                 rsp_allocated;
    logic                 rsp_legal;
    logic                 rsp_store;
    logic                 bypass_hit;
    logic [OffWidth-1:0]  rsp_offset;
    logic [Depth-1:0]     slot_set;

    assign alloc_ready_o = (count_reg < DepthCnt);
    assign alloc_id_o    = alloc_ptr_reg;
    assign empty_o       = (count_reg == '0);
    assign full_o        = (count_reg == DepthCnt);
    assign alloc_fire    = alloc_valid_i & alloc_ready_o;
    assign head_filled   = ~empty_o & filled_reg[head_ptr_reg];

    // Distance of the response slot from head in allocation order
    always_comb begin
        rsp_offset = '0;
        if ({1'b0, rsp_id_i} >= {1'b0, head_ptr_reg}) begin
            rsp_offset = {1'b0, rsp_id_i} - {1'b0, head_ptr_reg};
        end else begin
            rsp_offset = {1'b0, rsp_id_i} + DepthOff - {1'b0, head_ptr_reg};
        end
    end

    // A slot is outstanding when it lies within count entries of head
    assign rsp_in_range  = ({1'b0, rsp_id_i} < DepthOff);
    assign rsp_allocated = rsp_in_range & (rsp_offset < OffWidth'(count_reg));
    assign rsp_legal     = rsp_valid_i & rsp_allocated & ~filled_reg[rsp_id_i];

`ifdef SPATZ_VLSU_ROB_BYPASS_EN
    assign bypass_hit = rsp_legal & (rsp_id_i == head_ptr_reg);
`else
    assign bypass_hit = 1'b0;
`endif

    assign pop_valid_o = head_filled | bypass_hit;
    assign pop_data_o  = head_filled ? data_reg[head_ptr_reg]
                       : (bypass_hit ? rsp_data_i : '0);
    assign pop_fire    = pop_valid_o & pop_ready_i;

    // A bypassed response consumed this cycle never occupies its slot
    assign rsp_store = rsp_legal & ~(bypass_hit & pop_fire);

    // Per-slot fill bookkeeping: set by a stored response, cleared on alloc or pop
    for (genvar gi = 0; gi < Depth; gi++) begin : g_slot
        localparam logic [IdWidth-1:0] SlotId = IdWidth'(gi);
        logic clr_fill;
        assign slot_set[gi]    = rsp_store & (rsp_id_i == SlotId);
        assign clr_fill        = (alloc_fire & (alloc_ptr_reg == SlotId))
                               | (pop_fire & (head_ptr_reg == SlotId));
        assign filled_next[gi] = slot_set[gi] | (filled_reg[gi] & ~clr_fill);
    end

    // Pointer and occupancy next-state
    always_comb begin
        alloc_ptr_next = alloc_fire ? ptr_inc(alloc_ptr_reg) : alloc_ptr_reg;
        head_ptr_next  = pop_fire ? ptr_inc(head_ptr_reg) : head_ptr_reg;
        count_next     = count_reg;
        if (alloc_fire && !pop_fire) begin
            count_next = count_reg + CntWidth'(1);
        end else if (!alloc_fire && pop_fire) begin
            count_next = count_reg - CntWidth'(1);
        end
    end

    // Control state; reset discards every outstanding slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alloc_ptr_reg <= '0;
            head_ptr_reg  <= '0;
            count_reg     <= '0;
            filled_reg    <= '0;
        end else begin
            alloc_ptr_reg <= alloc_ptr_next;
            head_ptr_reg  <= head_ptr_next;
            count_reg     <= count_next;
            filled_reg    <= filled_next;
        end
    end

    // Slot data; qualified by the filled bits, so no reset is needed
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < Depth; i++) begin
            if (slot_set[i]) begin
                data_reg[i] <= rsp_data_i;
            end
        end
    end

`ifndef SYNTHESIS
    // Responses must target an outstanding slot that has not been filled yet
    rsp_legal_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_valid_i |-> rsp_legal);
`endif

endmodule
